// File: rtl/fft_peak_finder_if.sv
// Stream-in / result-out bundle for fft_peak_finder.
// master: the side that feeds FFT bins and takes results.
// slave:  the peak finder itself.
interface fft_peak_finder_if #(
    parameter int NFFT = 1024,
    parameter int DW   = 16
);
    logic [2*DW-1:0]         s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tlast;
    logic                    s_axis_tready;
    logic [$clog2(NFFT)-1:0] peak_bin;
    logic [2*DW-1:0]         peak_mag;
    logic                    frame_err;
    logic                    result_valid;
    logic                    result_ready;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, result_ready,
        input  s_axis_tready, peak_bin, peak_mag, frame_err, result_valid
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, result_ready,
        output s_axis_tready, peak_bin, peak_mag, frame_err, result_valid
    );
endinterface

// File: rtl/fft_peak_finder.sv
// fft_peak_finder: consumes one complex FFT frame, finds the lower-half bin
// with the largest re^2+im^2, and reports it with a tlast framing-error flag.
// Optional build macro FFT_PEAK_SKIP_DC_EN: when defined, bin 0 is excluded
// from the search (peak_bin stays 0 if no other bin is nonzero).
module fft_peak_finder #(
    parameter int NFFT = 1024,
    parameter int DW   = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    fft_peak_finder_if.slave   bus
);
    localparam int BW = $clog2(NFFT);
    localparam int MW = 2 * DW;

    typedef enum logic [1:0] {RECV, DRAIN, HOLD} state_t;

    state_t          r_state;
    logic            r_tready;
    logic [BW-1:0]   r_cnt;
    logic [1:0]      r_drain;
    logic            r_err;

    logic            r_result_valid;
    logic [BW-1:0]   r_peak_bin;
    logic [MW-1:0]   r_peak_mag;
    logic            r_frame_err;

    logic signed [MW-1:0] r_re2;
    logic signed [MW-1:0] r_im2;
    logic [BW-1:0]   r_s1_bin;
    logic            r_s1_vld;

    logic [BW-1:0]   r_best_bin;
    logic [MW-1:0]   r_best_mag;

    logic                 w_acc;
    logic                 w_last_cnt;
    logic                 w_frame_end;
    logic                 w_bad_last;
    logic                 w_clr;
    logic signed [MW-1:0] w_re_x;
    logic signed [MW-1:0] w_im_x;
    logic [MW-1:0]        w_mag;
    logic                 w_cmp_en;

    // tready is only ever high in RECV, so it alone qualifies the handshake
    assign w_acc       = bus.s_axis_tvalid & r_tready;
    assign w_last_cnt  = &r_cnt;
    assign w_frame_end = bus.s_axis_tlast | w_last_cnt;
    assign w_bad_last  = bus.s_axis_tlast ^ w_last_cnt;
    assign w_clr       = (r_state == HOLD) & bus.result_ready;

    // Sign-extend to product width so the square keeps all its bits
    assign w_re_x = {{DW{bus.s_axis_tdata[DW-1]}},   bus.s_axis_tdata[DW-1:0]};
    assign w_im_x = {{DW{bus.s_axis_tdata[MW-1]}},   bus.s_axis_tdata[MW-1:DW]};

    // Both squares are non-negative; their sum peaks at 2^(2DW-1), which fits unsigned
    assign w_mag = $unsigned(r_re2) + $unsigned(r_im2);

`ifdef FFT_PEAK_SKIP_DC_EN
    assign w_cmp_en = r_s1_vld & ~r_s1_bin[BW-1] & (r_s1_bin != '0);
`else
    assign w_cmp_en = r_s1_vld & ~r_s1_bin[BW-1];
`endif

    // Stage 1: square both components and carry the bin index along
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_re2    <= '0;
            r_im2    <= '0;
            r_s1_bin <= '0;
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_acc;
            if (w_acc) begin
                r_re2    <= w_re_x * w_re_x;
                r_im2    <= w_im_x * w_im_x;
                r_s1_bin <= r_cnt;
            end
        end
    end

    // Stage 2: running maximum; strict compare keeps the lowest bin on ties
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_best_mag <= '0;
            r_best_bin <= '0;
        end else if (w_clr) begin
            r_best_mag <= '0;
            r_best_bin <= '0;
        end else if (w_cmp_en && (w_mag > r_best_mag)) begin
            r_best_mag <= w_mag;
            r_best_bin <= r_s1_bin;
        end
    end

    // Control FSM: RECV counts beats, DRAIN lets the pipeline empty, HOLD presents the result.
    // DRAIN spans the cycle after the final beat plus two more, so the result
    // latches on the third edge after that beat.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state        <= RECV;
            r_tready       <= 1'b0;
            r_cnt          <= '0;
            r_drain        <= '0;
            r_err          <= 1'b0;
            r_result_valid <= 1'b0;
            r_peak_bin     <= '0;
            r_peak_mag     <= '0;
            r_frame_err    <= 1'b0;
        end else begin
            case (r_state)
                RECV: begin
                    r_tready <= 1'b1;
                    if (w_acc) begin
                        if (w_frame_end) begin
                            r_state  <= DRAIN;
                            r_tready <= 1'b0;
                            r_cnt    <= '0;
                            r_drain  <= 2'd2;
                            r_err    <= w_bad_last;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (r_drain == 2'd0) begin
                        r_state        <= HOLD;
                        r_result_valid <= 1'b1;
                        r_peak_bin     <= r_best_bin;
                        r_peak_mag     <= r_best_mag;
                        r_frame_err    <= r_err;
                    end else begin
                        r_drain <= r_drain - 2'd1;
                    end
                end
                HOLD: begin
                    if (bus.result_ready) begin
                        r_state        <= RECV;
                        r_result_valid <= 1'b0;
                        r_tready       <= 1'b1;
                        r_err          <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= RECV;
                    r_tready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_axis_tready = r_tready;
    assign bus.result_valid  = r_result_valid;
    assign bus.peak_bin      = r_peak_bin;
    assign bus.peak_mag      = r_peak_mag;
    assign bus.frame_err     = r_frame_err;

endmodule
